// File: rtl/matmul_stream_engine.sv
// SRAM-to-SRAM matrix multiply C = A x B (or A x B^T), one dot product at a time through a single MAC.
// Headers give dimensions; C is written row-major with optional saturation to DATA_W.
module matmul_stream_engine #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned ACC_W  = 80,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [ADDR_W-1:0] cfg_a_base,
  input  logic [ADDR_W-1:0] cfg_b_base,
  input  logic [ADDR_W-1:0] cfg_c_base,
  input  logic              cfg_transpose_b,
  input  logic              cfg_sat,
  output logic [ADDR_W-1:0] a_rd_addr,
  input  logic [DATA_W-1:0] a_rd_data,
  output logic [ADDR_W-1:0] b_rd_addr,
  input  logic [DATA_W-1:0] b_rd_data,
  output logic              c_wr_en,
  output logic [ADDR_W-1:0] c_wr_addr,
  output logic [DATA_W-1:0] c_wr_data,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_CHECK, S_RUN, S_DRAIN, S_DONE, S_ERR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [ADDR_W-1:0] a_row_q, a_row_d, b_col_q, b_col_d, b_first_q, b_first_d;
  logic [15:0]       k_q, k_d, j_q, j_d, i_q, i_d;
  logic [2:0]        hdr_cnt_q, hdr_cnt_d;
  logic [31:0]       hdr_a_q, hdr_a_d, hdr_b_q, hdr_b_d;
  logic              tr_q, tr_d, sat_q, sat_d;
  logic [3:0]        iss_q, iss_d;            // {valid, first, last, final}
  logic [3:0]        pipe_q [RD_LAT];
  logic [ACC_W-1:0]  acc_q;
  logic [ADDR_W-1:0] wr_ptr_q, c_wr_addr_q;
  logic [DATA_W-1:0] c_wr_data_q;
  logic              c_wr_en_q, wr_final_q, done_q, err_q, start_ready_q;

  logic [15:0]       m_dim, k_dim, n_dim;
  logic              dim_err, accept;
  logic [ADDR_W-1:0] b_kstep, b_jstep;

  assign accept  = start_valid && start_ready_q;
  assign m_dim   = hdr_a_q[31:16];
  assign k_dim   = hdr_a_q[15:0];
  assign n_dim   = tr_q ? hdr_b_q[31:16] : hdr_b_q[15:0];
  assign dim_err = (m_dim == '0) || (k_dim == '0) || (n_dim == '0) ||
                   (tr_q ? (hdr_b_q[15:0] != k_dim) : (hdr_b_q[31:16] != k_dim));
  assign b_kstep = tr_q ? ADDR_W'(1) : ADDR_W'(n_dim);
  assign b_jstep = tr_q ? ADDR_W'(k_dim) : ADDR_W'(1);

  always_comb begin
    state_d   = state_q;
    a_addr_d  = a_addr_q;
    b_addr_d  = b_addr_q;
    a_row_d   = a_row_q;
    b_col_d   = b_col_q;
    b_first_d = b_first_q;
    k_d       = k_q;
    j_d       = j_q;
    i_d       = i_q;
    hdr_cnt_d = hdr_cnt_q;
    hdr_a_d   = hdr_a_q;
    hdr_b_d   = hdr_b_q;
    tr_d      = tr_q;
    sat_d     = sat_q;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d   = S_HDR;
        a_addr_d  = cfg_a_base;
        b_addr_d  = cfg_b_base;
        hdr_cnt_d = '0;
        tr_d      = cfg_transpose_b;
        sat_d     = cfg_sat;
      end
      S_HDR: begin
        hdr_cnt_d = hdr_cnt_q + 3'd1;
        if (hdr_cnt_q == 3'(RD_LAT)) begin
          hdr_a_d = a_rd_data[31:0];
          hdr_b_d = b_rd_data[31:0];
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (dim_err) begin
          state_d = S_ERR;
        end else begin
          // Header addresses are still held, so element 0 sits one word above them.
          state_d   = S_RUN;
          a_addr_d  = a_addr_q + ADDR_W'(1);
          a_row_d   = a_addr_q + ADDR_W'(1);
          b_addr_d  = b_addr_q + ADDR_W'(1);
          b_col_d   = b_addr_q + ADDR_W'(1);
          b_first_d = b_addr_q + ADDR_W'(1);
          k_d       = '0;
          j_d       = '0;
          i_d       = '0;
        end
      end
      S_RUN: begin
        if (k_q != k_dim - 16'd1) begin
          k_d      = k_q + 16'd1;
          a_addr_d = a_addr_q + ADDR_W'(1);
          b_addr_d = b_addr_q + b_kstep;
        end else if (j_q != n_dim - 16'd1) begin
          k_d      = '0;
          j_d      = j_q + 16'd1;
          a_addr_d = a_row_q;
          b_col_d  = b_col_q + b_jstep;
          b_addr_d = b_col_q + b_jstep;
        end else if (i_q != m_dim - 16'd1) begin
          k_d      = '0;
          j_d      = '0;
          i_d      = i_q + 16'd1;
          a_row_d  = a_row_q + ADDR_W'(k_dim);
          a_addr_d = a_row_q + ADDR_W'(k_dim);
          b_col_d  = b_first_q;
          b_addr_d = b_first_q;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (c_wr_en_q && wr_final_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    iss_d[3] = (state_d == S_RUN);
    iss_d[2] = (k_d == '0);
    iss_d[1] = (k_d == k_dim - 16'd1);
    iss_d[0] = iss_d[1] && (j_d == n_dim - 16'd1) && (i_d == m_dim - 16'd1);
  end

  logic [3:0]          p_out;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    acc_sum;
  logic [DATA_W-1:0]   c_val;

  assign p_out   = pipe_q[RD_LAT-1];
  assign prod    = (2*DATA_W)'(a_rd_data) * (2*DATA_W)'(b_rd_data);
  assign acc_sum = (p_out[2] ? '0 : acc_q) + ACC_W'(prod);
  assign c_val   = (sat_q && (|acc_sum[ACC_W-1:DATA_W])) ? '1 : acc_sum[DATA_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      a_addr_q      <= '0;
      b_addr_q      <= '0;
      a_row_q       <= '0;
      b_col_q       <= '0;
      b_first_q     <= '0;
      k_q           <= '0;
      j_q           <= '0;
      i_q           <= '0;
      hdr_cnt_q     <= '0;
      hdr_a_q       <= '0;
      hdr_b_q       <= '0;
      tr_q          <= 1'b0;
      sat_q         <= 1'b0;
      iss_q         <= '0;
      for (int unsigned n = 0; n < RD_LAT; n++) pipe_q[n] <= '0;
      acc_q         <= '0;
      wr_ptr_q      <= '0;
      c_wr_en_q     <= 1'b0;
      c_wr_addr_q   <= '0;
      c_wr_data_q   <= '0;
      wr_final_q    <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      start_ready_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      a_addr_q      <= a_addr_d;
      b_addr_q      <= b_addr_d;
      a_row_q       <= a_row_d;
      b_col_q       <= b_col_d;
      b_first_q     <= b_first_d;
      k_q           <= k_d;
      j_q           <= j_d;
      i_q           <= i_d;
      hdr_cnt_q     <= hdr_cnt_d;
      hdr_a_q       <= hdr_a_d;
      hdr_b_q       <= hdr_b_d;
      tr_q          <= tr_d;
      sat_q         <= sat_d;
      iss_q         <= iss_d;
      pipe_q[0]     <= iss_q;
      for (int unsigned n = 1; n < RD_LAT; n++) pipe_q[n] <= pipe_q[n-1];
      if (p_out[3]) acc_q <= acc_sum;
      if (accept) wr_ptr_q <= cfg_c_base;
      c_wr_en_q     <= p_out[3] && p_out[1];
      wr_final_q    <= p_out[3] && p_out[1] && p_out[0];
      if (p_out[3] && p_out[1]) begin
        c_wr_addr_q <= wr_ptr_q;
        c_wr_data_q <= c_val;
        wr_ptr_q    <= wr_ptr_q + ADDR_W'(1);
      end
      done_q        <= (state_d == S_DONE) || (state_d == S_ERR);
      err_q         <= (state_d == S_ERR);
      start_ready_q <= (state_d == S_IDLE);
    end
  end

  assign start_ready = start_ready_q;
  assign a_rd_addr   = a_addr_q;
  assign b_rd_addr   = b_addr_q;
  assign c_wr_en     = c_wr_en_q;
  assign c_wr_addr   = c_wr_addr_q;
  assign c_wr_data   = c_wr_data_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
